// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like slave port between the IF master (inst_*)
//    and the MEM master (data_*), returning each response only to the master that issued it.
// Latency: address path is combinational (no added cycles); responses are routed
//    combinationally from m_sram_data_ok using an in-order owner tag FIFO.
// Backpressure: slave addr_ok stalls hold (lock) the current grant; at most OUTSTANDING
//    accepted-but-unanswered transactions, beyond which m_sram_en is held low.
//
// Ports:
//    clk, reset                      clock, asynchronous active-high reset
//    inst_sram_* (en/wr/size/wen/addr/wdata in, addr_ok/data_ok/rdata out)   IF master
//    data_sram_* (en/wr/size/wen/addr/wdata in, addr_ok/data_ok/rdata out)   MEM master
//    m_sram_*    (en/wr/size/wen/addr/wdata out, addr_ok/data_ok/rdata in)   slave side
//
// Optional feature, macro ARB_RR_EN:
//    defined   - unlocked contention alternates between masters (last accepted loses)
//    undefined - fixed priority, data master over instruction master

// Small in-order FIFO with a registered occupancy count and a head peek.
// Latency: one cycle from push to visibility at the head when empty.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module sram_arb_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_dat,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;

   // Pointers are exactly log2(DEPTH) wide so they wrap on their own.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_dat = mem[rd_ptr];

endmodule

module sram_bus_arbiter #(
   parameter int OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        inst_sram_en,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [3:0]  inst_sram_wen,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,

   input  logic        data_sram_en,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,

   output logic        m_sram_en,
   output logic        m_sram_wr,
   output logic [1:0]  m_sram_size,
   output logic [3:0]  m_sram_wen,
   output logic [31:0] m_sram_addr,
   output logic [31:0] m_sram_wdata,
   input  logic        m_sram_addr_ok,
   input  logic        m_sram_data_ok,
   input  logic [31:0] m_sram_rdata
);

   localparam int            PW      = $clog2(OUTSTANDING);
   localparam int            CW      = PW + 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(OUTSTANDING);
   localparam logic          ID_INST = 1'b0;
   localparam logic          ID_DATA = 1'b1;

   logic [CW-1:0] cnt;
   logic          head_tag;
   logic          can_issue;
   logic          grant_vld;
   logic          grant_id;
   logic          lock_vld;
   logic          lock_id;
   logic          accept;
   logic          pop;
   logic          err_q;
   logic          unused_err;

`ifdef ARB_RR_EN
   logic          last_id;
`endif

   // Full check looks only at the registered count: a same-cycle pop does not
   // free a slot, which keeps m_sram_data_ok out of the m_sram_en timing path.
   assign can_issue = (cnt < MAX_CNT);

   // ------------------------------------------------------------------
   // Grant select
   // ------------------------------------------------------------------
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = ID_INST;
      if (can_issue) begin
         if (lock_vld) begin
            // A stalled address phase keeps its owner until addr_ok.
            grant_vld = 1'b1;
            grant_id  = lock_id;
         end
`ifdef ARB_RR_EN
         else if (data_sram_en && inst_sram_en) begin
            // Contention: whoever was accepted last yields.
            grant_vld = 1'b1;
            grant_id  = ~last_id;
         end
`endif
         else if (data_sram_en) begin
            grant_vld = 1'b1;
            grant_id  = ID_DATA;
         end else if (inst_sram_en) begin
            grant_vld = 1'b1;
            grant_id  = ID_INST;
         end
      end
   end

   // ------------------------------------------------------------------
   // Slave request mux; everything reads zero without a grant or in reset
   // ------------------------------------------------------------------
   always_comb begin
      m_sram_en    = 1'b0;
      m_sram_wr    = 1'b0;
      m_sram_size  = 2'b00;
      m_sram_wen   = 4'h0;
      m_sram_addr  = 32'h0;
      m_sram_wdata = 32'h0;
      if (grant_vld && !reset) begin
         if (grant_id == ID_DATA) begin
            m_sram_en    = data_sram_en;
            m_sram_wr    = data_sram_wr;
            m_sram_size  = data_sram_size;
            m_sram_wen   = data_sram_wen;
            m_sram_addr  = data_sram_addr;
            m_sram_wdata = data_sram_wdata;
         end else begin
            m_sram_en    = inst_sram_en;
            m_sram_wr    = inst_sram_wr;
            m_sram_size  = inst_sram_size;
            m_sram_wen   = inst_sram_wen;
            m_sram_addr  = inst_sram_addr;
            m_sram_wdata = inst_sram_wdata;
         end
      end
   end

   // m_sram_en already implies a valid grant and no reset.
   assign accept            = m_sram_en && m_sram_addr_ok;
   assign inst_sram_addr_ok = accept && (grant_id == ID_INST);
   assign data_sram_addr_ok = accept && (grant_id == ID_DATA);

   // ------------------------------------------------------------------
   // Owner tag FIFO: one entry per accepted, not yet answered transaction
   // ------------------------------------------------------------------
   assign pop = m_sram_data_ok && (cnt != '0);

   sram_arb_fifo #(
      .WIDTH (1),
      .DEPTH (OUTSTANDING)
   ) u_tag_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (accept),
      .push_dat (grant_id),
      .pop      (pop),
      .head_dat (head_tag),
      .count    (cnt)
   );

   // ------------------------------------------------------------------
   // Response routing by the head tag
   // ------------------------------------------------------------------
   assign inst_sram_data_ok = pop && (head_tag == ID_INST) && !reset;
   assign data_sram_data_ok = pop && (head_tag == ID_DATA) && !reset;
   assign inst_sram_rdata   = (!reset && head_tag == ID_INST) ? m_sram_rdata : 32'h0;
   assign data_sram_rdata   = (!reset && head_tag == ID_DATA) ? m_sram_rdata : 32'h0;

   // ------------------------------------------------------------------
   // Grant lock and the spurious-response debug flag
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_vld <= 1'b0;
         lock_id  <= ID_INST;
         err_q    <= 1'b0;
      end else begin
         if (m_sram_en && !m_sram_addr_ok) begin
            lock_vld <= 1'b1;
            lock_id  <= grant_id;
         end else if (m_sram_addr_ok) begin
            lock_vld <= 1'b0;
         end
         // A response with nothing outstanding is dropped; remember that it happened.
         if (m_sram_data_ok && (cnt == '0)) begin
            err_q <= 1'b1;
         end
      end
   end

   // err_q is a debug-only flag, observed through hierarchy rather than a port.
   assign unused_err = err_q;

`ifdef ARB_RR_EN
   // Reset value ID_INST makes the data master win the first contention.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_id <= ID_INST;
      end else if (accept) begin
         last_id <= grant_id;
      end
   end
`endif

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter (OUTSTANDING=2): reset, single fetch,
// contention, lock, FIFO-full, response ordering and mid-transaction reset.
module tb_sram_bus_arbiter;

   logic        clk;
   logic        reset;
   logic        inst_sram_en, inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr, inst_sram_wdata;
   logic        inst_sram_addr_ok, inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_en, data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr, data_sram_wdata;
   logic        data_sram_addr_ok, data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        m_sram_en, m_sram_wr;
   logic [1:0]  m_sram_size;
   logic [3:0]  m_sram_wen;
   logic [31:0] m_sram_addr, m_sram_wdata;
   logic        m_sram_addr_ok, m_sram_data_ok;
   logic [31:0] m_sram_rdata;

   int total;
   int bad;

   typedef struct {
      logic        is_data;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   logic model_last;

   sram_bus_arbiter #(.OUTSTANDING(2)) dut (
      .clk               (clk),
      .reset             (reset),
      .inst_sram_en      (inst_sram_en),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_wen     (inst_sram_wen),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_wdata   (inst_sram_wdata),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .data_sram_en      (data_sram_en),
      .data_sram_wr      (data_sram_wr),
      .data_sram_size    (data_sram_size),
      .data_sram_wen     (data_sram_wen),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wdata   (data_sram_wdata),
      .data_sram_addr_ok (data_sram_addr_ok),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .m_sram_en         (m_sram_en),
      .m_sram_wr         (m_sram_wr),
      .m_sram_size       (m_sram_size),
      .m_sram_wen        (m_sram_wen),
      .m_sram_addr       (m_sram_addr),
      .m_sram_wdata      (m_sram_wdata),
      .m_sram_addr_ok    (m_sram_addr_ok),
      .m_sram_data_ok    (m_sram_data_ok),
      .m_sram_rdata      (m_sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_inst(input logic en, input logic [31:0] addr);
      inst_sram_en    = en;
      inst_sram_wr    = 1'b0;
      inst_sram_size  = 2'd2;
      inst_sram_wen   = 4'h0;
      inst_sram_addr  = addr;
      inst_sram_wdata = 32'h0;
   endtask

   task automatic set_data(input logic en, input logic wr, input logic [3:0] wen,
                           input logic [31:0] addr, input logic [31:0] wdata);
      data_sram_en    = en;
      data_sram_wr    = wr;
      data_sram_size  = 2'd2;
      data_sram_wen   = wen;
      data_sram_addr  = addr;
      data_sram_wdata = wdata;
   endtask

   task automatic idle();
      set_inst(1'b0, 32'h0);
      set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      m_sram_addr_ok = 1'b0;
      m_sram_data_ok = 1'b0;
      m_sram_rdata   = 32'h0;
   endtask

   // Expected response owner in acceptance order; also tracks the last accepted master.
   task automatic sb_push(input logic is_data, input logic [31:0] rd);
      exp_t e;
      e.is_data = is_data;
      e.rdata   = rd;
      sb.push_back(e);
      model_last = is_data;
   endtask

   function automatic logic exp_winner();
`ifdef ARB_RR_EN
      return ~model_last;
`else
      return 1'b1;
`endif
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      model_last = 1'b0;
      set_inst(1'b1, 32'hbfc00000);
      set_data(1'b1, 1'b1, 4'hf, 32'h1000, 32'h1);
      m_sram_addr_ok = 1'b1;
      m_sram_data_ok = 1'b1;
      m_sram_rdata   = 32'hdeadbeef;
      #2;
      total++;
      if ({m_sram_en, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctl: en/aok/aok/dok/dok=%b want 00000",
                  {m_sram_en, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok});
      end
      total++;
      if ({inst_sram_rdata, data_sram_rdata, m_sram_addr} !== 96'h0) begin
         bad++;
         $display("FAIL reset_dat: irdata=%h drdata=%h maddr=%h want all 0", inst_sram_rdata, data_sram_rdata, m_sram_addr);
      end
      step();
      step();
      idle();
      reset = 1'b0;
      #2;
      total++;
      if (dut.cnt !== 2'd0 || m_sram_en !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: cnt=%0d m_en=%b want cnt=0 m_en=0", dut.cnt, m_sram_en);
      end
   endtask

   task automatic test_priority();
      logic w;
      idle();
      set_inst(1'b1, 32'h0000_3100);
      set_data(1'b1, 1'b0, 4'h0, 32'h0000_3200, 32'h0);
      m_sram_addr_ok = 1'b1;
      w = exp_winner();
      #2;
      total++;
      if (m_sram_addr !== (w ? 32'h3200 : 32'h3100) || {data_sram_addr_ok, inst_sram_addr_ok} !== {w, ~w}) begin
         bad++;
         $display("FAIL prio_first: addr=%h dok=%b iok=%b want winner data=%b", m_sram_addr, data_sram_addr_ok, inst_sram_addr_ok, w);
      end
      sb_push(w, 32'h0000_a001);
      step();
      if (w) set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      else   set_inst(1'b0, 32'h0);
      #2;
      total++;
      if (m_sram_addr !== (w ? 32'h3100 : 32'h3200) || {data_sram_addr_ok, inst_sram_addr_ok} !== {~w, w}) begin
         bad++;
         $display("FAIL prio_second: addr=%h dok=%b iok=%b want winner data=%b", m_sram_addr, data_sram_addr_ok, inst_sram_addr_ok, ~w);
      end
      sb_push(~w, 32'h0000_a002);
      step();
      idle();
      for (int k = 0; k < 2; k++) begin
         exp_t e;
         e = sb.pop_front();
         m_sram_data_ok = 1'b1;
         m_sram_rdata   = e.rdata;
         #2;
         total++;
         if ({inst_sram_data_ok, data_sram_data_ok} !== {~e.is_data, e.is_data} ||
             {inst_sram_rdata, data_sram_rdata} !== (e.is_data ? {32'h0, e.rdata} : {e.rdata, 32'h0})) begin
            bad++;
            $display("FAIL prio_resp%0d: iok=%b dok=%b ird=%h drd=%h want owner data=%b rdata=%h",
                     k, inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata, data_sram_rdata, e.is_data, e.rdata);
         end
         step();
      end
      m_sram_data_ok = 1'b0;
   endtask

   task automatic test_single_inst();
      exp_t e;
      idle();
      set_inst(1'b1, 32'hbfc00000);
      m_sram_addr_ok = 1'b1;
      #2;
      total++;
      if (m_sram_en !== 1'b1 || m_sram_addr !== 32'hbfc00000 || m_sram_wr !== 1'b0 || m_sram_size !== 2'd2 ||
          inst_sram_addr_ok !== 1'b1 || data_sram_addr_ok !== 1'b0) begin
         bad++;
         $display("FAIL single_addr: en=%b addr=%h wr=%b size=%0d iok=%b dok=%b want 1 bfc00000 0 2 1 0",
                  m_sram_en, m_sram_addr, m_sram_wr, m_sram_size, inst_sram_addr_ok, data_sram_addr_ok);
      end
      sb_push(1'b0, 32'h3c1dbfc0);
      step();
      idle();
      #2;
      total++;
      if (dut.cnt !== 2'd1 || inst_sram_data_ok !== 1'b0) begin
         bad++;
         $display("FAIL single_wait: cnt=%0d iok=%b want 1 0", dut.cnt, inst_sram_data_ok);
      end
      step();
      e = sb.pop_front();
      m_sram_data_ok = 1'b1;
      m_sram_rdata   = e.rdata;
      #2;
      total++;
      if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== e.rdata || data_sram_data_ok !== 1'b0) begin
         bad++;
         $display("FAIL single_resp: iok=%b ird=%h dok=%b want 1 %h 0", inst_sram_data_ok, inst_sram_rdata, data_sram_data_ok, e.rdata);
      end
      step();
      m_sram_data_ok = 1'b0;
      #2;
      total++;
      if (dut.cnt !== 2'd0) begin
         bad++;
         $display("FAIL single_cnt: cnt=%0d want 0", dut.cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ia;
      logic [31:0] da;
      logic        w;
      idle();
      ia = 32'h0000_1000;
      da = 32'h0000_2000;
      for (int c = 0; c < 4; c++) begin
         exp_t e;
         set_inst(1'b1, ia);
         set_data(1'b1, 1'b0, 4'h0, da, 32'h0);
         m_sram_addr_ok = 1'b1;
         m_sram_data_ok = 1'b0;
         if (c > 0) begin
            e = sb.pop_front();
            m_sram_data_ok = 1'b1;
            m_sram_rdata   = e.rdata;
         end
         w = exp_winner();
         #2;
         total++;
         if (m_sram_addr !== (w ? da : ia) || {data_sram_addr_ok, inst_sram_addr_ok} !== {w, ~w}) begin
            bad++;
            $display("FAIL b2b_grant%0d: addr=%h dok=%b iok=%b want winner data=%b", c, m_sram_addr, data_sram_addr_ok, inst_sram_addr_ok, w);
         end
         if (c > 0) begin
            total++;
            if ({inst_sram_data_ok, data_sram_data_ok} !== {~e.is_data, e.is_data} ||
                (e.is_data ? data_sram_rdata : inst_sram_rdata) !== e.rdata) begin
               bad++;
               $display("FAIL b2b_resp%0d: iok=%b dok=%b want owner data=%b rdata=%h", c, inst_sram_data_ok, data_sram_data_ok, e.is_data, e.rdata);
            end
         end
         sb_push(w, 32'hb000_0000 + 32'(c));
         step();
         if (w) da = da + 32'd4;
         else   ia = ia + 32'd4;
      end
      $display("back_to_back: last accepted master data=%b", model_last);
      // Data withdraws; the still-waiting inst master gets the very next grant.
      begin
         exp_t e;
         set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         e = sb.pop_front();
         m_sram_data_ok = 1'b1;
         m_sram_rdata   = e.rdata;
         #2;
         total++;
         if (m_sram_addr !== ia || inst_sram_addr_ok !== 1'b1 || data_sram_data_ok !== e.is_data) begin
            bad++;
            $display("FAIL b2b_inst_next: addr=%h iok=%b dok=%b want %h 1 %b", m_sram_addr, inst_sram_addr_ok, data_sram_data_ok, ia, e.is_data);
         end
         sb_push(1'b0, 32'hb000_00ff);
         step();
         idle();
         e = sb.pop_front();
         m_sram_data_ok = 1'b1;
         m_sram_rdata   = e.rdata;
         #2;
         total++;
         if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== e.rdata) begin
            bad++;
            $display("FAIL b2b_last_resp: iok=%b ird=%h want 1 %h", inst_sram_data_ok, inst_sram_rdata, e.rdata);
         end
         step();
         m_sram_data_ok = 1'b0;
      end
   endtask

   task automatic test_lock();
      idle();
      set_inst(1'b1, 32'h0000_3000);
      for (int c = 0; c < 4; c++) begin
         if (c == 1) set_data(1'b1, 1'b0, 4'h0, 32'h0000_4000, 32'h0);
         m_sram_addr_ok = (c == 3);
         #2;
         total++;
         if (m_sram_addr !== 32'h3000 || inst_sram_addr_ok !== (c == 3) || data_sram_addr_ok !== 1'b0) begin
            bad++;
            $display("FAIL lock_hold%0d: addr=%h iok=%b dok=%b want 00003000 %b 0", c, m_sram_addr, inst_sram_addr_ok, data_sram_addr_ok, (c == 3));
         end
         if (c == 3) sb_push(1'b0, 32'h0000_c001);
         step();
      end
      set_inst(1'b0, 32'h0);
      #2;
      total++;
      if (m_sram_addr !== 32'h4000 || data_sram_addr_ok !== 1'b1) begin
         bad++;
         $display("FAIL lock_release: addr=%h dok=%b want 00004000 1", m_sram_addr, data_sram_addr_ok);
      end
      sb_push(1'b1, 32'h0000_c002);
      step();
      idle();
      for (int k = 0; k < 2; k++) begin
         exp_t e;
         e = sb.pop_front();
         m_sram_data_ok = 1'b1;
         m_sram_rdata   = e.rdata;
         #2;
         total++;
         if ({inst_sram_data_ok, data_sram_data_ok} !== {~e.is_data, e.is_data} ||
             (e.is_data ? data_sram_rdata : inst_sram_rdata) !== e.rdata) begin
            bad++;
            $display("FAIL lock_resp%0d: iok=%b dok=%b want owner data=%b rdata=%h", k, inst_sram_data_ok, data_sram_data_ok, e.is_data, e.rdata);
         end
         step();
      end
      m_sram_data_ok = 1'b0;
   endtask

   task automatic test_full();
      exp_t e;
      idle();
      m_sram_addr_ok = 1'b1;
      for (int c = 0; c < 2; c++) begin
         set_inst(1'b1, 32'h0000_5000 + 32'(4 * c));
         #2;
         total++;
         if (inst_sram_addr_ok !== 1'b1) begin
            bad++;
            $display("FAIL full_fill%0d: iok=%b want 1", c, inst_sram_addr_ok);
         end
         sb_push(1'b0, 32'h0000_d000 + 32'(c));
         step();
      end
      set_inst(1'b1, 32'h0000_5008);
      #2;
      total++;
      if (m_sram_en !== 1'b0 || inst_sram_addr_ok !== 1'b0 || dut.cnt !== 2'd2) begin
         bad++;
         $display("FAIL full_block: m_en=%b iok=%b cnt=%0d want 0 0 2", m_sram_en, inst_sram_addr_ok, dut.cnt);
      end
      step();
      e = sb.pop_front();
      m_sram_data_ok = 1'b1;
      m_sram_rdata   = e.rdata;
      #2;
      total++;
      if (m_sram_en !== 1'b0 || inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== e.rdata) begin
         bad++;
         $display("FAIL full_pop: m_en=%b iok=%b ird=%h want 0 1 %h", m_sram_en, inst_sram_data_ok, inst_sram_rdata, e.rdata);
      end
      step();
      m_sram_data_ok = 1'b0;
      #2;
      total++;
      if (m_sram_en !== 1'b1 || inst_sram_addr_ok !== 1'b1 || m_sram_addr !== 32'h5008) begin
         bad++;
         $display("FAIL full_resume: m_en=%b iok=%b addr=%h want 1 1 00005008", m_sram_en, inst_sram_addr_ok, m_sram_addr);
      end
      sb_push(1'b0, 32'h0000_d002);
      step();
      idle();
      for (int k = 0; k < 2; k++) begin
         exp_t r;
         r = sb.pop_front();
         m_sram_data_ok = 1'b1;
         m_sram_rdata   = r.rdata;
         #2;
         total++;
         if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== r.rdata || data_sram_data_ok !== 1'b0) begin
            bad++;
            $display("FAIL full_resp%0d: iok=%b ird=%h dok=%b want 1 %h 0", k, inst_sram_data_ok, inst_sram_rdata, data_sram_data_ok, r.rdata);
         end
         step();
      end
      m_sram_data_ok = 1'b0;
      #2;
      total++;
      if (dut.cnt !== 2'd0) begin
         bad++;
         $display("FAIL full_cnt: cnt=%0d want 0", dut.cnt);
      end
   endtask

   task automatic test_ordering();
      exp_t e;
      idle();
      m_sram_addr_ok = 1'b1;
      set_inst(1'b1, 32'h0000_6000);
      #2;
      total++;
      if (inst_sram_addr_ok !== 1'b1) begin
         bad++;
         $display("FAIL order_acc0: iok=%b want 1", inst_sram_addr_ok);
      end
      sb_push(1'b0, 32'h0000_e000);
      step();
      set_inst(1'b0, 32'h0);
      set_data(1'b1, 1'b1, 4'hf, 32'h0000_7000, 32'h55aa55aa);
      #2;
      total++;
      if (data_sram_addr_ok !== 1'b1 || m_sram_wr !== 1'b1 || m_sram_wen !== 4'hf ||
          m_sram_addr !== 32'h7000 || m_sram_wdata !== 32'h55aa55aa) begin
         bad++;
         $display("FAIL order_write: dok=%b wr=%b wen=%h addr=%h wdata=%h want 1 1 f 00007000 55aa55aa",
                  data_sram_addr_ok, m_sram_wr, m_sram_wen, m_sram_addr, m_sram_wdata);
      end
      sb_push(1'b1, 32'h0000_e001);
      step();
      set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_inst(1'b1, 32'h0000_6004);
      e = sb.pop_front();
      m_sram_data_ok = 1'b1;
      m_sram_rdata   = e.rdata;
      #2;
      total++;
      if (inst_sram_data_ok !== 1'b1 || data_sram_data_ok !== 1'b0 || inst_sram_rdata !== e.rdata || m_sram_en !== 1'b0) begin
         bad++;
         $display("FAIL order_resp0: iok=%b dok=%b ird=%h m_en=%b want 1 0 %h 0", inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata, m_sram_en, e.rdata);
      end
      step();
      m_sram_data_ok = 1'b0;
      #2;
      total++;
      if (inst_sram_addr_ok !== 1'b1) begin
         bad++;
         $display("FAIL order_acc2: iok=%b want 1", inst_sram_addr_ok);
      end
      sb_push(1'b0, 32'h0000_e002);
      step();
      idle();
      for (int k = 1; k < 3; k++) begin
         exp_t r;
         r = sb.pop_front();
         m_sram_data_ok = 1'b1;
         m_sram_rdata   = r.rdata;
         #2;
         total++;
         if ({inst_sram_data_ok, data_sram_data_ok} !== {~r.is_data, r.is_data} ||
             {inst_sram_rdata, data_sram_rdata} !== (r.is_data ? {32'h0, r.rdata} : {r.rdata, 32'h0})) begin
            bad++;
            $display("FAIL order_resp%0d: iok=%b dok=%b ird=%h drd=%h want owner data=%b rdata=%h",
                     k, inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata, data_sram_rdata, r.is_data, r.rdata);
         end
         step();
      end
      m_sram_data_ok = 1'b0;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      idle();
      set_data(1'b1, 1'b0, 4'h0, 32'h0000_8000, 32'h0);
      m_sram_addr_ok = 1'b1;
      #2;
      total++;
      if (data_sram_addr_ok !== 1'b1) begin
         bad++;
         $display("FAIL rmid_acc: dok=%b want 1", data_sram_addr_ok);
      end
      step();
      set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_inst(1'b1, 32'h0000_9000);
      m_sram_addr_ok = 1'b0;
      step();
      #2;
      total++;
      if (dut.cnt !== 2'd1 || dut.lock_vld !== 1'b1) begin
         bad++;
         $display("FAIL rmid_setup: cnt=%0d lock=%b want 1 1", dut.cnt, dut.lock_vld);
      end
      m_sram_addr_ok = 1'b1;
      m_sram_data_ok = 1'b1;
      m_sram_rdata   = 32'h12345678;
      reset = 1'b1;
      #1;
      total++;
      if ({m_sram_en, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== 5'b0 ||
          {inst_sram_rdata, data_sram_rdata} !== 64'h0) begin
         bad++;
         $display("FAIL rmid_outputs: en/aok/aok/dok/dok=%b ird=%h drd=%h want all 0",
                  {m_sram_en, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok}, inst_sram_rdata, data_sram_rdata);
      end
      total++;
      if (dut.cnt !== 2'd0 || dut.lock_vld !== 1'b0) begin
         bad++;
         $display("FAIL rmid_state: cnt=%0d lock=%b want 0 0", dut.cnt, dut.lock_vld);
      end
      step();
      sb.delete();
      model_last = 1'b0;
      m_sram_data_ok = 1'b0;
      set_inst(1'b1, 32'hbfc00000);
      reset = 1'b0;
      #2;
      total++;
      if (m_sram_en !== 1'b1 || m_sram_addr !== 32'hbfc00000 || inst_sram_addr_ok !== 1'b1) begin
         bad++;
         $display("FAIL rmid_fresh: m_en=%b addr=%h iok=%b want 1 bfc00000 1", m_sram_en, m_sram_addr, inst_sram_addr_ok);
      end
      sb_push(1'b0, 32'h3c1dbfc0);
      step();
      idle();
      e = sb.pop_front();
      m_sram_data_ok = 1'b1;
      m_sram_rdata   = e.rdata;
      #2;
      total++;
      if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== e.rdata) begin
         bad++;
         $display("FAIL rmid_resp: iok=%b ird=%h want 1 %h", inst_sram_data_ok, inst_sram_rdata, e.rdata);
      end
      step();
      m_sram_data_ok = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      model_last = 1'b0;
      test_reset();
      test_priority();
      test_single_inst();
      test_back_to_back();
      test_lock();
      test_full();
      test_ordering();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
